// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, write-through bypass
// and a per-register busy scoreboard for outstanding load destinations.
`default_nettype none

module reg_file_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic                     we0_i,
  input  logic [ADDR_W-1:0]        waddr0_i,
  input  logic [DATA_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [ADDR_W-1:0]        waddr1_i,
  input  logic [DATA_W-1:0]        wdata1_i,
  input  logic                     rsv_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [(2**ADDR_W)-1:0]   busy_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Effective enables: reset suppresses both the state update and the bypass.
  logic wr0_en, wr1_en, rsv_en;
  assign wr0_en = we0_i & ~rst_i & (waddr0_i != '0);
  assign wr1_en = we1_i & ~rst_i & (waddr1_i != '0);
  assign rsv_en = rsv_i & ~rst_i & (rsv_addr_i != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else begin
      if (wr0_en) regs[waddr0_i] <= wdata0_i;
      if (wr1_en) regs[waddr1_i] <= wdata1_i;
    end
  end

  // Set beats clear: a new reservation belongs to a newer producer than the write.
  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (rsv_en && rsv_addr_i == ADDR_W'(i)) begin
        busy_nxt[i] = 1'b1;
      end else if ((wr0_en && waddr0_i == ADDR_W'(i)) ||
                   (wr1_en && waddr1_i == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b0;
      end else begin
        busy_nxt[i] = busy[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_o = busy;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit0;
      logic              hit1;

      assign addr = raddr_i[k*ADDR_W +: ADDR_W];
      assign hit0 = wr0_en && (waddr0_i == addr);
      assign hit1 = wr1_en && (waddr1_i == addr);

      assign rdata_o[k*DATA_W +: DATA_W] = (addr == '0) ? '0       :
                                           hit1         ? wdata1_i :
                                           hit0         ? wdata0_i :
                                                          regs[addr];
      assign rbusy_o[k] = busy[addr] & ~(hit0 | hit1);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against an
// array-based reference model of registers and reservations.
`default_nettype none

module tb_reg_file_mp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
  logic [1:0]  rbusy_o;
  logic        we0_i, we1_i, rsv_i;
  logic [4:0]  waddr0_i, waddr1_i, rsv_addr_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic [31:0] busy_o;

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_IDX(29), .SP_INIT(128)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rbusy_o(rbusy_o), .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i), .rsv_i(rsv_i),
    .rsv_addr_i(rsv_addr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd(input int k);
    return rdata_o[k*32 +: 32];
  endfunction

  task automatic set_ra(input int k, input logic [4:0] a);
    raddr_i[k*5 +: 5] = a;
  endtask

  task automatic idle();
    we0_i = 0; we1_i = 0; rsv_i = 0;
    waddr0_i = 0; waddr1_i = 0; rsv_addr_i = 0;
    wdata0_i = 0; wdata1_i = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = (i == 29) ? 32'd128 : 32'd0;
    m_busy = 0;
  endtask

  // One clock: inputs already driven after a negedge. Expected reads are the
  // register contents as they will stand after this edge.
  task automatic cycle();
    logic [31:0] post [32];
    logic [31:0] wr;
    logic [4:0]  a;
    if (rst_i) model_reset();
    post = m_reg;
    wr = 0;
    if (!rst_i) begin
      if (we0_i && waddr0_i != 0) begin post[waddr0_i] = wdata0_i; wr[waddr0_i] = 1; end
      if (we1_i && waddr1_i != 0) begin post[waddr1_i] = wdata1_i; wr[waddr1_i] = 1; end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      a = raddr_i[k*5 +: 5];
      chk("rdata", rd(k), (a == 0) ? 32'd0 : post[a]);
      chk("rbusy", {31'd0, rbusy_o[k]}, {31'd0, m_busy[a] & ~wr[a]});
    end
    chk("busy_o", busy_o, m_busy);
    @(posedge clk_i);
    if (!rst_i) begin
      m_reg = post;
      for (int i = 1; i < 32; i++) begin
        if (rsv_i && rsv_addr_i == 5'(i)) m_busy[i] = 1'b1;
        else if (wr[i]) m_busy[i] = 1'b0;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1; raddr_i = 0; idle();
    model_reset();
    set_ra(0, 29); set_ra(1, 1);
    #2;
    chk("rst_sp", rd(0), 32'd128);
    chk("rst_r1", rd(1), 32'd0);
    chk("rst_busy", busy_o, 32'd0);
    set_ra(1, 0);
    #1 chk("rst_r0", rd(1), 32'd0);
    @(negedge clk_i);
    rst_i = 0;

    // Bypass then stored value
    we0_i = 1; waddr0_i = 5; wdata0_i = 32'hDEADBEEF; set_ra(0, 5);
    #1 chk("byp_5", rd(0), 32'hDEADBEEF);
    cycle();
    idle();
    #1 chk("store_5", rd(0), 32'hDEADBEEF);
    cycle();

    // Same-address collision: port 1 wins
    we0_i = 1; waddr0_i = 7; wdata0_i = 32'h11;
    we1_i = 1; waddr1_i = 7; wdata1_i = 32'h22; set_ra(0, 7); set_ra(1, 8);
    #1 chk("coll_byp", rd(0), 32'h22);
    cycle();
    idle();
    #1 chk("coll_store", rd(0), 32'h22);
    we0_i = 1; waddr0_i = 7; wdata0_i = 32'h11;
    we1_i = 1; waddr1_i = 8; wdata1_i = 32'h22;
    cycle();
    idle();
    #1 chk("split_7", rd(0), 32'h11);
    chk("split_8", rd(1), 32'h22);

    // Register 0 ignores writes and reserves
    we0_i = 1; waddr0_i = 0; wdata0_i = 32'hFFFF; set_ra(0, 0);
    cycle();
    idle(); rsv_i = 1; rsv_addr_i = 0;
    cycle();
    idle();
    #1 chk("r0_read", rd(0), 32'd0);
    chk("r0_busy", {31'd0, busy_o[0]}, 32'd0);

    // Reservation lifecycle on register 9
    set_ra(0, 9);
    rsv_i = 1; rsv_addr_i = 9;
    cycle();
    idle();
    #1 chk("rsv9_busy", {31'd0, busy_o[9]}, 32'd1);
    chk("rsv9_rbusy", {31'd0, rbusy_o[0]}, 32'd1);
    cycle();
    cycle();
    we1_i = 1; waddr1_i = 9; wdata1_i = 32'h55;
    #1 chk("ret9_rbusy", {31'd0, rbusy_o[0]}, 32'd0);
    chk("ret9_data", rd(0), 32'h55);
    cycle();
    idle();
    #1 chk("ret9_clear", {31'd0, busy_o[9]}, 32'd0);
    rsv_i = 1; rsv_addr_i = 9; we0_i = 1; waddr0_i = 9; wdata0_i = 32'h66;
    cycle();
    idle();
    #1 chk("setwins9", {31'd0, busy_o[9]}, 32'd1);

    // Asynchronous reset between edges
    we0_i = 1; waddr0_i = 3; wdata0_i = 32'h77; rsv_i = 1; rsv_addr_i = 4;
    cycle();
    idle(); set_ra(0, 3); set_ra(1, 29);
    #2 rst_i = 1;
    #1 chk("arst_r3", rd(0), 32'd0);
    chk("arst_busy", busy_o, 32'd0);
    chk("arst_sp", rd(1), 32'd128);
    model_reset();
    @(negedge clk_i);
    rst_i = 0;

    // Randomized traffic, addresses biased toward a small range for collisions
    for (int n = 0; n < 400; n++) begin
      rst_i      = ($urandom_range(0, 59) == 0);
      we0_i      = $urandom_range(0, 1);
      we1_i      = ($urandom_range(0, 2) == 0);
      rsv_i      = ($urandom_range(0, 2) == 0);
      waddr0_i   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      waddr1_i   = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      rsv_addr_i = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata0_i   = $urandom;
      wdata1_i   = $urandom;
      set_ra(0, $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom));
      set_ra(1, $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom));
      cycle();
      rst_i = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS core. Replaces the single-write, negedge-write register file.
- Writes on the rising edge. Combinational write-through bypass gives read-after-write in the same cycle.
- Two write ports: WB and a late load-return path.
- A per-register busy scoreboard lets the hazard unit stall on outstanding load destinations without a separate tracking block.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- SP_IDX, 29, index of stack-pointer register given a non-zero reset value
- SP_INIT, 128, reset value of register SP_IDX

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous active-high reset
- raddr_i  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  NUM_RD*DATA_W  packed read data, same packing
- rbusy_o  out  NUM_RD  per read port: addressed register has an outstanding reservation
- we0_i  in  1  write enable, port 0 (WB)
- waddr0_i  in  ADDR_W  write address, port 0
- wdata0_i  in  DATA_W  write data, port 0
- we1_i  in  1  write enable, port 1 (load return)
- waddr1_i  in  ADDR_W  write address, port 1
- wdata1_i  in  DATA_W  write data, port 1
- rsv_i  in  1  reserve destination (load issued)
- rsv_addr_i  in  ADDR_W  register to mark busy
- busy_o  out  2**ADDR_W  full scoreboard vector, bit i = register i busy

Behaviour:
Reset
- rst_i high, asynchronous: all registers = 0 except reg[SP_IDX] = SP_INIT; all busy bits = 0.
- While rst_i is high, writes and reserves are ignored.
- rdata_o reflects reset contents combinationally.
- rst_i asserted mid-operation discards all pending reservations and in-flight writes.

Register 0
- Always reads 0.
- Writes and reserves to address 0 are ignored; busy[0] is constantly 0.

Write
- On posedge clk_i, if weN_i is high and waddrN_i != 0: reg[waddrN_i] <= wdataN_i.
- Both ports to the same address in the same cycle: port 1 wins.
- Different addresses: both writes land.

Read (combinational, zero latency)
- rdata port k = 0 if addr==0.
- Else wdata1_i if we1_i and waddr1_i==addr.
- Else wdata0_i if we0_i and waddr0_i==addr.
- Else reg[addr].
- Bypass priority matches the write priority, so read data equals the value the register holds after the edge.

Scoreboard (per nonzero register i)
- Set: posedge with rsv_i and rsv_addr_i==i.
- Clear: posedge with a write (either port) to i.
- Set and clear to the same i in the same cycle: set wins (newer producer).
- Re-reserving a busy register leaves it busy; no counting.
- rbusy_o[k] = busy[addr_k] AND NOT (write to addr_k this cycle). A write arriving this cycle is bypassed, so the consumer does not stall.
- busy_o is the raw registered vector, with no bypass masking.

Invariants
- No X on any output after reset for any input sequence with defined inputs.
- Reads never alter state.

Test Plan:
- Reset → rdata for addr 29 = 128, addr 1 = 0, addr 0 = 0; busy_o = 0.
- we0, waddr0=5, wdata0=0xDEADBEEF; same cycle raddr port0=5 → rdata port0 = 0xDEADBEEF before the edge; after the edge with we0=0, still 0xDEADBEEF.
- we0 (addr 7, 0x11) and we1 (addr 7, 0x22) in the same cycle → bypass reads 0x22; stored value 0x22. Repeat with addrs 7 and 8 → 0x11 and 0x22 respectively.
- we0, waddr0=0, wdata0=0xFFFF → reg0 reads 0. rsv_i to addr 0 → busy_o[0]=0.
- Cycle 1: rsv addr 9 → busy_o[9]=1 and rbusy=1 while reading 9. Cycle 4: we1 addr 9, 0x55 → that cycle rbusy=0 and rdata=0x55; next cycle busy_o[9]=0. Separately, rsv and we0 to addr 9 in the same cycle → busy_o[9]=1.
- Write reg3=0x77 and reserve reg4, then pulse rst_i between clock edges → immediately reg3=0, busy_o=0, reg29=128.
